// File: rtl/ddr3_resp_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_resp_pkg
// Shared definitions for the DDR3 responder model: command encodings, burst
// engine states, error codes, power-on latencies and the burst column helper.
// No ports; imported by the responder top and its bank table.
// ---------------------------------------------------------------------------
package ddr3_resp_pkg;

  // {ras_n, cas_n, we_n} as seen on the command strobes
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } burst_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CLOSED  = 3'd1;
  localparam logic [2:0] ERR_REACT   = 3'd2;
  localparam logic [2:0] ERR_BUSY    = 3'd3;
  localparam logic [2:0] ERR_REFOPEN = 3'd4;

  localparam logic [3:0] DEF_CL  = 4'd6;
  localparam logic [3:0] DEF_CWL = 4'd5;
  localparam int         BL      = 8;

  // Sequential burst order: the low three column bits wrap inside the
  // 8-aligned block, the upper bits never change during a burst.
  function automatic logic [9:0] beatCol(input logic [9:0] col, input logic [2:0] beat);
    logic [2:0] low;
    low = col[2:0] + beat;
    return {col[9:3], low};
  endfunction

endpackage

// File: rtl/ddr3_resp_if.sv
// ---------------------------------------------------------------------------
// ddr3_resp_if
// Command/data bundle between a DDR3 controller (master) and the responder
// model (slave).
//   cke, cs_n, ras_n, cas_n, we_n : command strobes
//   ba, addr                      : bank and row/column/mode address
//   dm                            : write byte mask, 1 = lane masked
//   odt                           : on-die termination, not modelled
//   dq_i / dq_o / dq_oe           : write data, read data, read data valid
//   err / err_code                : sticky protocol error and its first code
// ---------------------------------------------------------------------------
interface ddr3_resp_if #(
  parameter int DQ_W = 16
);

  logic              cke;
  logic              cs_n;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic [2:0]        ba;
  logic [14:0]       addr;
  logic [DQ_W/8-1:0] dm;
  logic              odt;
  logic [DQ_W-1:0]   dq_i;
  logic [DQ_W-1:0]   dq_o;
  logic              dq_oe;
  logic              err;
  logic [2:0]        err_code;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm, odt, dq_i,
    input  dq_o, dq_oe, err, err_code
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm, odt, dq_i,
    output dq_o, dq_oe, err, err_code
  );

endinterface

// File: rtl/ddr3_resp_bank_tbl.sv
// ---------------------------------------------------------------------------
// ddr3_resp_bank_tbl
// Per-bank open flag and open row for the eight DDR3 banks.
//   clk, resetn            : clock, synchronous active-low reset
//   i_act/i_actBank/i_actRow : open a bank with a row (caller checks legality)
//   i_pre/i_preAll/i_preBank : close one bank or all banks
//   i_autoClose/i_autoBank   : close the bank of a finished auto-precharge burst
//   o_open, o_row            : current open flags and open rows
// ---------------------------------------------------------------------------
module ddr3_resp_bank_tbl (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_act,
  input  logic [2:0]       i_actBank,
  input  logic [14:0]      i_actRow,
  input  logic             i_pre,
  input  logic             i_preAll,
  input  logic [2:0]       i_preBank,
  input  logic             i_autoClose,
  input  logic [2:0]       i_autoBank,
  output logic [7:0]       o_open,
  output logic [7:0][14:0] o_row
);

  logic [7:0]       r_open;
  logic [7:0][14:0] r_row;

  // Each bank is opened by ACT and closed by either precharge flavour or by
  // the end of an auto-precharge burst. The top only forwards an ACT to a
  // closed bank, so an open and a close never target the same bank together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_open <= '0;
      r_row  <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (i_act && (i_actBank == 3'(b))) begin
          r_open[b] <= 1'b1;
          r_row[b]  <= i_actRow;
        end else if ((i_pre && (i_preAll || (i_preBank == 3'(b)))) ||
                     (i_autoClose && (i_autoBank == 3'(b)))) begin
          r_open[b] <= 1'b0;
        end
      end
    end
  end

  assign o_open = r_open;
  assign o_row  = r_row;

endmodule

// File: rtl/ddr3_resp.sv
// ---------------------------------------------------------------------------
// ddr3_resp
// Behavioural DDR3 device responder: decodes commands, tracks open banks,
// runs BL8 read/write bursts with programmable CL/CWL against internal
// storage, and flags the first protocol violation.
//   clk    : sole clock, commands sampled on the rising edge
//   resetn : synchronous active-low reset
//   ddr    : ddr3_resp_if slave port (strobes, address, data, error status)
// ---------------------------------------------------------------------------
module ddr3_resp
  import ddr3_resp_pkg::*;
#(
  parameter int DQ_W   = 16,
  parameter int MEM_AW = 10
) (
  input logic       clk,
  input logic       resetn,
  ddr3_resp_if.slave ddr
);

  localparam int LANES = DQ_W / 8;

  logic [DQ_W-1:0] r_mem [2**MEM_AW];

  burst_e          r_state;
  logic [3:0]      r_lat;
  logic [2:0]      r_beat;
  logic            r_isWr;
  logic            r_ap;
  logic [2:0]      r_bank;
  logic [14:0]     r_row;
  logic [9:0]      r_col;
  logic [3:0]      r_cl;
  logic [3:0]      r_cwl;
  logic            r_dqOe;
  logic [DQ_W-1:0] r_dqO;
  logic            r_err;
  logic [2:0]      r_errCode;

  logic            w_cmdValid;
  cmd_e            w_cmd;
  logic            w_isMrs, w_isRef, w_isPre, w_isAct, w_isWr, w_isRd, w_rwReq;
  logic [7:0]      w_open;
  logic [7:0][14:0] w_row;
  logic            w_bankOpen;
  logic            w_rwAccept;
  logic            w_actOk;
  logic            w_errEvt;
  logic [2:0]      w_errCode;
  logic            w_rdFire;
  logic [2:0]      w_rdBeat;
  logic            w_wrFire;
  logic            w_autoClose;
  logic [27:0]     w_rdFull, w_wrFull;
  logic [MEM_AW-1:0] w_rdIdx, w_wrIdx;
  logic            w_unusedBits;

  // Commands exist only with the chip selected, clock enabled and the part
  // out of reset; ZQ and NOP simply decode to nothing.
  assign w_cmdValid = resetn && !ddr.cs_n && ddr.cke;
  assign w_cmd      = cmd_e'({ddr.ras_n, ddr.cas_n, ddr.we_n});
  assign w_isMrs    = w_cmdValid && (w_cmd == CMD_MRS);
  assign w_isRef    = w_cmdValid && (w_cmd == CMD_REF);
  assign w_isPre    = w_cmdValid && (w_cmd == CMD_PRE);
  assign w_isAct    = w_cmdValid && (w_cmd == CMD_ACT);
  assign w_isWr     = w_cmdValid && (w_cmd == CMD_WR);
  assign w_isRd     = w_cmdValid && (w_cmd == CMD_RD);
  assign w_rwReq    = w_isWr || w_isRd;
  assign w_bankOpen = w_open[ddr.ba];
  assign w_rwAccept = w_rwReq && (r_state == ST_IDLE) && w_bankOpen;
  assign w_actOk    = w_isAct && !w_bankOpen;

  // Error classification for the command on the bus this cycle. A busy
  // engine outranks a closed bank because the burst could never start.
  always_comb begin
    w_errEvt  = 1'b0;
    w_errCode = ERR_NONE;
    if (w_rwReq && (r_state != ST_IDLE)) begin
      w_errEvt  = 1'b1;
      w_errCode = ERR_BUSY;
    end else if (w_rwReq && !w_bankOpen) begin
      w_errEvt  = 1'b1;
      w_errCode = ERR_CLOSED;
    end else if (w_isAct && w_bankOpen) begin
      w_errEvt  = 1'b1;
      w_errCode = ERR_REACT;
    end else if (w_isRef && (|w_open)) begin
      w_errEvt  = 1'b1;
      w_errCode = ERR_REFOPEN;
    end
  end

  // The XFER state mirrors the beat on the pins, so read data for the next
  // beat is fetched one edge ahead: on leaving WAIT (beat 0) or while
  // stepping through XFER (beats 1..7).
  assign w_rdFire    = !r_isWr && (((r_state == ST_WAIT) && (r_lat == 4'd0)) ||
                                   ((r_state == ST_XFER) && (r_beat != 3'(BL-1))));
  assign w_rdBeat    = (r_state == ST_WAIT) ? 3'd0 : (r_beat + 3'd1);
  assign w_wrFire    = resetn && r_isWr && (r_state == ST_XFER);
  assign w_autoClose = resetn && r_ap && (r_state == ST_XFER) && (r_beat == 3'(BL-1));

  // Storage index is the low MEM_AW bits of {bank, row, column}; the
  // higher bits simply alias.
  assign w_rdFull = {r_bank, r_row, beatCol(r_col, w_rdBeat)};
  assign w_wrFull = {r_bank, r_row, beatCol(r_col, r_beat)};
  assign w_rdIdx  = w_rdFull[MEM_AW-1:0];
  assign w_wrIdx  = w_wrFull[MEM_AW-1:0];
  assign w_unusedBits = ^{w_rdFull, w_wrFull, ddr.odt};

  ddr3_resp_bank_tbl u_bankTbl (
    .clk        (clk),
    .resetn     (resetn),
    .i_act      (w_actOk),
    .i_actBank  (ddr.ba),
    .i_actRow   (ddr.addr),
    .i_pre      (w_isPre),
    .i_preAll   (ddr.addr[10]),
    .i_preBank  (ddr.ba),
    .i_autoClose(w_autoClose),
    .i_autoBank (r_bank),
    .o_open     (w_open),
    .o_row      (w_row)
  );

  // Burst engine, mode registers, read data pins and sticky error. The
  // latency counter is loaded with L-2 so that XFER starts exactly L cycles
  // after the cycle the command was on the bus. Latencies are captured at
  // accept time, so an MRS only affects later bursts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_lat     <= '0;
      r_beat    <= '0;
      r_isWr    <= 1'b0;
      r_ap      <= 1'b0;
      r_bank    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_cl      <= DEF_CL;
      r_cwl     <= DEF_CWL;
      r_dqOe    <= 1'b0;
      r_dqO     <= '0;
      r_err     <= 1'b0;
      r_errCode <= ERR_NONE;
    end else begin
      if (w_isMrs && (ddr.ba == 3'd0)) r_cl  <= 4'd4 + {1'b0, ddr.addr[6:4]};
      if (w_isMrs && (ddr.ba == 3'd2)) r_cwl <= 4'd5 + {1'b0, ddr.addr[5:3]};

      if (w_errEvt && !r_err) begin
        r_err     <= 1'b1;
        r_errCode <= w_errCode;
      end

      r_dqOe <= w_rdFire;
      r_dqO  <= w_rdFire ? r_mem[w_rdIdx] : '0;

      case (r_state)
        ST_IDLE: begin
          if (w_rwAccept) begin
            r_state <= ST_WAIT;
            r_lat   <= (w_isWr ? r_cwl : r_cl) - 4'd2;
            r_isWr  <= w_isWr;
            r_ap    <= ddr.addr[10];
            r_bank  <= ddr.ba;
            r_row   <= w_row[ddr.ba];
            r_col   <= ddr.addr[9:0];
          end
        end
        ST_WAIT: begin
          if (r_lat == 4'd0) begin
            r_state <= ST_XFER;
            r_beat  <= 3'd0;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        ST_XFER: begin
          if (r_beat == 3'(BL-1)) r_state <= ST_IDLE;
          else                    r_beat  <= r_beat + 3'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write port with per-lane enables. Storage has no reset so its contents
  // survive a reset; a reset mid-burst stops further beats via w_wrFire.
  always_ff @(posedge clk) begin
    if (w_wrFire) begin
      for (int l = 0; l < LANES; l++) begin
        if (!ddr.dm[l]) r_mem[w_wrIdx][l*8 +: 8] <= ddr.dq_i[l*8 +: 8];
      end
    end
  end

  assign ddr.dq_o     = r_dqO;
  assign ddr.dq_oe    = r_dqOe;
  assign ddr.err      = r_err;
  assign ddr.err_code = r_errCode;

endmodule

// File: doc/ddr3_resp.md
DDR3_RESP -- requirements
Module: ddr3_resp

Interface
REQ-001 Parameter DQ_W, default 16, data bus width (two byte lanes).
REQ-002 Parameter MEM_AW, default 10, log2 of internal storage words.
REQ-003 Ports: clk in 1, sole clock; resetn in 1, synchronous active-low reset; one clock, reset synchronous and active-low.
REQ-004 Ports: cke in 1; cs_n in 1; ras_n in 1; cas_n in 1; we_n in 1, command strobes sampled on the rising edge of clk.
REQ-005 Ports: ba in 3, bank; addr in 15, row/column/mode; dm in 2, write byte mask, 1 = lane masked; odt in 1, ignored.
REQ-006 Ports: dq_i in DQ_W, write data; dq_o out DQ_W, read data; dq_oe out 1, read data valid/drive enable.
REQ-007 Ports: err out 1, sticky protocol error; err_code out 3, code of the first error.

Function
REQ-008 Command valid only when cs_n=0 and cke=1; {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQ (treated as NOP), 111 NOP.
REQ-009 MRS ba=0 sets CL = 4 + addr[6:4]; MRS ba=2 sets CWL = 5 + addr[5:3]; other banks ignored; new values apply to later RD/WR only.
REQ-010 ACT opens bank ba with row addr; ACT to an already open bank sets error code 2, command ignored.
REQ-011 PRE with addr[10]=1 closes all banks; otherwise closes bank ba; PRE to a closed bank is legal, no effect.
REQ-012 REF with any bank open sets error code 4; otherwise no effect.
REQ-013 RD/WR to a closed bank sets error code 1, command ignored.
REQ-014 Burst engine states: IDLE, WAIT (latency count), XFER (8 beats); RD/WR accepted only in IDLE; otherwise error code 3, ignored.
REQ-015 RD accepted at cycle N: dq_oe=1 exactly on cycles N+CL .. N+CL+7, dq_o carrying beats 0..7.
REQ-016 WR accepted at cycle N: dq_i/dm sampled on cycles N+CWL .. N+CWL+7 as beats 0..7; masked lanes leave storage unchanged.
REQ-017 Beat k column = {col[9:3], (col[2:0]+k) mod 8}, i.e. sequential wrap within the 8-aligned block.
REQ-018 Storage index = low MEM_AW bits of {ba, row, beat column}; aliasing beyond MEM_AW is accepted behaviour.
REQ-019 RD/WR with addr[10]=1 (auto-precharge) closes the bank on the cycle after the last beat; an ACT to that bank is legal from then.
REQ-020 WAIT->XFER when latency count reaches 0; XFER->IDLE after beat 7; a new RD/WR on the cycle of beat 7 is rejected (error 3), on the following cycle accepted.
REQ-021 Read after a completed write burst returns the written data; storage never initialised.
REQ-022 err set on first error and held; err_code latched at first error, later errors do not overwrite; simultaneous events impossible (one command per cycle).
REQ-023 dq_o = 0 whenever dq_oe=0.

Reset
REQ-024 resetn=0 at an edge: state IDLE, all banks closed, CL=6, CWL=5, dq_oe=0, dq_o=0, err=0, err_code=0 from the next cycle.
REQ-025 Reset mid-burst aborts it: no further beats driven or written; storage contents retained.
REQ-026 Commands presented while resetn=0 are ignored.

Structure
REQ-027 Package ddr3_resp_pkg holds the command enum, error code constants (1 CLOSED, 2 REACT, 3 BUSY, 4 REFOPEN), default CL/CWL and BL=8.
REQ-028 Sub-module ddr3_resp_bank_tbl holds per-bank open flag and open row, with ACT/PRE/PRE-all/auto-close update ports.
REQ-029 Storage is one DQ_W x 2^MEM_AW array with per-lane write enable; read port may be registered one cycle ahead of dq_o.

Verification
REQ-030 Reset; ACT ba=1 row=0x0012; WR col=0x008 data 0x1000..0x1007 at N+5; RD col=0x008 -> dq_oe on N'+6..N'+13, data 0x1000..0x1007, err=0.
REQ-031 RD col=0x00D of that row -> beats 0x1005,0x1006,0x1007,0x1000,0x1001,0x1002,0x1003,0x1004 (wrap).
REQ-032 MRS ba=0 addr=0x0040 (CL=8); RD -> first dq_oe exactly 8 cycles after command.
REQ-033 WR with dm=2'b10 over lanes of 0xAAAA, data 0x5555 -> readback 0xAA55.
REQ-034 RD to closed bank 3 -> err=1, err_code=1, dq_oe stays 0; subsequent ACT to open bank -> err_code still 1.
REQ-035 Assert resetn=0 at beat 3 of a read -> dq_oe=0 next cycle; ACT to previously open bank after reset -> no error.
